gpio_input_conditioner: RTL and testbench
=========================================

// Module: gpio_input_conditioner
// PURPOSE
//   Conditions raw board switch/button inputs before they reach the MIPS core's 8-bit GPIO_i port.
//   Per bit: N-stage synchronizer, then a stability-count debouncer.
//   Emits a clean level bus plus one-cycle rise/fall/change event pulses.
//   The level bus drives the core GPIO path (sign-extended downstream). Event pulses feed the optional IRQ latch.
// PARAMETERS
//   WIDTH            8   number of GPIO bits conditioned
//   SYNC_STAGES      2   synchronizer flop depth per bit (>=2)
//   DEBOUNCE_CYCLES  16  consecutive stable clocks required to accept a new level (>=1)
//   CNT_WIDTH        5   per-bit counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//   clk        in   1      system clock, single clock domain
//   rst        in   1      synchronous, active-high reset
//   raw_i      in   WIDTH  asynchronous raw pin levels
//   gpio_o     out  WIDTH  debounced levels, to core GPIO_i
//   rise_o     out  WIDTH  1-cycle pulse: bit of gpio_o went 0->1
//   fall_o     out  WIDTH  1-cycle pulse: bit of gpio_o went 1->0
//   change_o   out  1      OR of rise_o|fall_o, same cycle
//   irq_clr_i  in   1      clears irq_o (used only with GPIO_IRQ_LATCH_EN)
//   irq_o      out  1      sticky event flag (used only with GPIO_IRQ_LATCH_EN)
// BEHAVIOUR
//   Reset (sync, rst=1 at a clk edge):
//     - all sync flops, counters, gpio_o, rise_o, fall_o, change_o and irq_o go to 0.
//     - A reset mid-count discards the count and the pending level.
//   Sync: s[i] = last synchronizer stage. No logic between sync stages.
//   Per-bit debounce, evaluated every clk edge:
//     - s[i]==gpio_o[i]: cnt[i]<=0.
//     - s[i]!=gpio_o[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
//     - s[i]!=gpio_o[i] and cnt[i]==DEBOUNCE_CYCLES-1: gpio_o[i]<=s[i], cnt[i]<=0.
//   Glitch rule: any return of s[i] to gpio_o[i] before acceptance zeroes cnt[i]. Shorter pulses are fully rejected.
//   Latency: raw_i settled before edge 1 -> gpio_o updates at edge SYNC_STAGES+DEBOUNCE_CYCLES (18 at defaults).
//   DEBOUNCE_CYCLES=1 degenerates to a plain synchronizer with latency SYNC_STAGES+1.
//   Events:
//     - rise_o/fall_o/change_o are registered and asserted exactly in the cycle gpio_o holds its new value.
//     - They are deasserted on the next edge; never high two cycles in a row for the same toggle.
//   Independence: bits count independently. Simultaneous acceptance on several bits gives one change_o cycle with multiple rise/fall bits set.
//   Counter never wraps: saturation is impossible because acceptance occurs at DEBOUNCE_CYCLES-1.
// CONFIGURATION
//   GPIO_IRQ_LATCH_EN defined:
//     - irq_o sets on any edge where change_o would be asserted.
//     - irq_o clears on irq_clr_i=1.
//     - Simultaneous set and clear: set wins, irq_o stays 1.
//   GPIO_IRQ_LATCH_EN undefined:
//     - ports still exist; irq_o tied 0, irq_clr_i ignored.
//     - no latch flop synthesized.
// TESTING
//   1 rst=1 two edges, raw_i=0xFF throughout -> gpio_o=0x00, pulses 0, irq_o=0 while rst high.
//   2 rst released, raw_i=0x00; raw_i[0] 0->1 and held -> gpio_o=0x01 exactly 18 edges later.
//     Same edge: rise_o=0x01 and change_o=1, both for 1 cycle only.
//   3 raw_i[3] high for 10 clocks then low -> gpio_o stays 0x00, no pulses, cnt[3] returns to 0.
//   4 raw_i 0x00->0xA5 on one edge -> all four bits accept on the same edge.
//     gpio_o=0xA5, rise_o=0xA5, single change_o pulse. Then 0xA5->0x00 -> fall_o=0xA5.
//   5 raw_i[7] 0->1, rst=1 at count 8 -> gpio_o[7]=0.
//     After release with raw still 1 -> full 18-edge latency from release before acceptance.
//   6 GPIO_IRQ_LATCH_EN: toggle bit 1 -> irq_o=1 stays high.
//     irq_clr_i on same edge as a new change -> irq_o remains 1; lone irq_clr_i -> 0.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// Per-bit synchronizer plus stability-count debouncer for board GPIO inputs, with registered edge pulses.
// Define GPIO_IRQ_LATCH_EN to build the sticky irq_o latch; otherwise irq_o is tied low.
module gpio_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o,
  input  logic             irq_clr_i,
  output logic             irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [CNT_WIDTH-1:0] cnt    [WIDTH];
  logic [WIDTH-1:0]     s;
  logic [WIDTH-1:0]     differ;
  logic [WIDTH-1:0]     accept;

  assign s = sync_q[SYNC_STAGES-1];

  // Plain flop chain: nothing may sit between stages or metastability can leak through.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_comb begin
    differ = s ^ gpio_o;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) accept[i] = differ[i] && (cnt[i] == CNT_MAX);
  end

  // A bit agreeing with gpio_o zeroes its count, so any glitch restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      gpio_o   <= '0;
      rise_o   <= '0;
      fall_o   <= '0;
      change_o <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || accept[i]) cnt[i] <= '0;
        else                         cnt[i] <= cnt[i] + 1'b1;
      end
      gpio_o   <= gpio_o ^ accept;
      rise_o   <= accept & s;
      fall_o   <= accept & ~s;
      change_o <= |accept;
    end
  end

`ifdef GPIO_IRQ_LATCH_EN
  // Set has priority so an event coinciding with a clear is never lost.
  always_ff @(posedge clk) begin
    if (rst)            irq_o <= 1'b0;
    else if (|accept)   irq_o <= 1'b1;
    else if (irq_clr_i) irq_o <= 1'b0;
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner; expected events are queued at stimulus time and matched by a monitor.
module tb_gpio_input_conditioner;

  localparam int LAT = 18;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw_i;
  logic [7:0] gpio_o, rise_o, fall_o;
  logic       change_o;
  logic       irq_clr_i;
  logic       irq_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [7:0] gpio;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;
  exp_t q[$];

  gpio_input_conditioner dut (
    .clk       (clk),
    .rst       (rst),
    .raw_i     (raw_i),
    .gpio_o    (gpio_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .change_o  (change_o),
    .irq_clr_i (irq_clr_i),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_event(input int lat, input logic [7:0] g, input logic [7:0] r,
                              input logic [7:0] f);
    exp_t e;
    e.cyc  = cyc + lat;
    e.gpio = g;
    e.rise = r;
    e.fall = f;
    q.push_back(e);
  endtask

  // Any cycle with an event pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (change_o !== 1'b0 || rise_o !== 8'h00 || fall_o !== 8'h00) begin
      check("event_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("event_gpio", {24'h0, gpio_o}, {24'h0, e.gpio});
        check("event_rise", {24'h0, rise_o}, {24'h0, e.rise});
        check("event_fall", {24'h0, fall_o}, {24'h0, e.fall});
        check("event_change", {31'h0, change_o}, 32'd1);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    raw_i     = 8'hFF;
    irq_clr_i = 1'b0;

    // Reset held two edges with all pins high
    for (int n = 0; n < 2; n++) begin
      tick(1);
      check("rst_gpio", {24'h0, gpio_o}, 32'h0);
      check("rst_rise", {24'h0, rise_o}, 32'h0);
      check("rst_fall", {24'h0, fall_o}, 32'h0);
      check("rst_change", {31'h0, change_o}, 32'h0);
      check("rst_irq", {31'h0, irq_o}, 32'h0);
    end

    rst   = 1'b0;
    raw_i = 8'h00;
    tick(4);
    check("idle_gpio", {24'h0, gpio_o}, 32'h0);

    // Single bit rise, exact latency
    raw_i = 8'h01;
    expect_event(LAT, 8'h01, 8'h01, 8'h00);
    tick(LAT - 1);
    check("lat_not_early", {24'h0, gpio_o}, 32'h00);
    tick(8);
    check("bit0_high", {24'h0, gpio_o}, 32'h01);

    // Glitches on bit 3: 10 high, 2 low, 10 high -- never 16 in a row
    raw_i = 8'h09; tick(10);
    raw_i = 8'h01; tick(2);
    raw_i = 8'h09; tick(10);
    raw_i = 8'h01; tick(20);
    check("glitch_gpio", {24'h0, gpio_o}, 32'h01);
    check("glitch_cnt3", 32'(dut.cnt[3]), 32'd0);

    raw_i = 8'h00;
    expect_event(LAT, 8'h00, 8'h00, 8'h01);
    tick(LAT + 7);

    // Multi-bit simultaneous acceptance
    raw_i = 8'hA5;
    expect_event(LAT, 8'hA5, 8'hA5, 8'h00);
    tick(LAT + 7);
    check("multi_gpio", {24'h0, gpio_o}, 32'hA5);
    raw_i = 8'h00;
    expect_event(LAT, 8'h00, 8'h00, 8'hA5);
    tick(LAT + 7);
    check("multi_fall_gpio", {24'h0, gpio_o}, 32'h00);

    // Reset mid-count on bit 7 discards progress
    raw_i = 8'h80;
    tick(10);
    rst = 1'b1;
    tick(1);
    check("midrst_gpio", {24'h0, gpio_o}, 32'h00);
    rst = 1'b0;
    expect_event(LAT, 8'h80, 8'h80, 8'h00);
    tick(LAT - 1);
    check("midrst_not_early", {24'h0, gpio_o}, 32'h00);
    tick(8);
    check("midrst_gpio_after", {24'h0, gpio_o}, 32'h80);

`ifdef GPIO_IRQ_LATCH_EN
    check("irq_after_events", {31'h0, irq_o}, 32'd1);
    irq_clr_i = 1'b1; tick(1); irq_clr_i = 1'b0;
    check("irq_lone_clr", {31'h0, irq_o}, 32'd0);
    raw_i = 8'h82;
    expect_event(LAT, 8'h82, 8'h02, 8'h00);
    tick(LAT + 3);
    check("irq_set", {31'h0, irq_o}, 32'd1);
    tick(3);
    check("irq_sticky", {31'h0, irq_o}, 32'd1);
    raw_i = 8'h80;
    expect_event(LAT, 8'h80, 8'h00, 8'h02);
    tick(LAT - 1);
    irq_clr_i = 1'b1; tick(1); irq_clr_i = 1'b0;
    check("irq_set_wins", {31'h0, irq_o}, 32'd1);
    tick(1);
    irq_clr_i = 1'b1; tick(1); irq_clr_i = 1'b0;
    check("irq_clr_after", {31'h0, irq_o}, 32'd0);
`else
    raw_i = 8'h82;
    expect_event(LAT, 8'h82, 8'h02, 8'h00);
    tick(LAT + 3);
    check("irq_tied_low", {31'h0, irq_o}, 32'd0);
    irq_clr_i = 1'b1; tick(1); irq_clr_i = 1'b0;
    check("irq_tied_low_clr", {31'h0, irq_o}, 32'd0);
`endif

    tick(5);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
